// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared control-bit indices and stage-register state encoding
package mips_pipe_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - payload holding register with load enable and async clear
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Load,
  input  logic [W-1:0] i_D,
  output logic [W-1:0] o_Q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_q <= '0;
    end else if (i_Load) begin
      r_q <= i_D;
    end
  end

  assign o_Q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid slot,
// flush, bubble masking of write controls and a saturating stall counter
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2,
  parameter int REG_W    = 5,
  parameter int CTRL_W   = 2,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                       i_Clk,
  input  logic                       Reset,
  input  logic                       i_Valid,
  output logic                       o_Ready,
  input  logic [NUM_DATA*DATA_W-1:0] i_Data,
  input  logic [REG_W-1:0]           i_WriteReg,
  input  logic [CTRL_W-1:0]          i_Ctrl,
  input  logic                       i_Flush,
  output logic                       o_Valid,
  input  logic                       i_Ready,
  output logic [NUM_DATA*DATA_W-1:0] o_Data,
  output logic [REG_W-1:0]           o_WriteReg,
  output logic [CTRL_W-1:0]          o_Ctrl,
  input  logic                       i_CntClr,
  output logic [CNT_W-1:0]           o_StallCnt
);

  localparam int PW = NUM_DATA*DATA_W + REG_W + CTRL_W;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in;
  logic             w_out;
  logic             w_main_load;
  logic             w_skid_load;
  logic             w_main_from_skid;
  logic [PW-1:0]    w_in_pay;
  logic [PW-1:0]    w_main_d;
  logic [PW-1:0]    w_main_q;
  logic [PW-1:0]    w_skid_q;
  logic [CNT_W-1:0] r_cnt;

  assign w_in_pay = {i_Data, i_WriteReg, i_Ctrl};
  assign o_Valid  = (r_state != ST_EMPTY);
  // With a skid slot, ready is a decode of the state flop only, breaking the i_Ready path.
  assign o_Ready  = (SKID != 0) ? (r_state != ST_SKID) : (~o_Valid | i_Ready);
  assign w_in     = i_Valid & o_Ready;
  assign w_out    = o_Valid & i_Ready;

  always_ff @(posedge i_Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FULL with in & ~out only arises when o_Ready is registered, so SKID=0 never enters ST_SKID.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    if (i_Flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in) begin
            w_main_load = 1'b1;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_in && !w_out) begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_SKID;
          end else if (w_in) begin
            w_main_load = 1'b1;
          end else if (w_out) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_out) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_FULL;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_pay;

  pipe_slot #(.W(PW)) u_main_slot (
    .i_Clk   (i_Clk),
    .i_Rst_n (Reset),
    .i_Load  (w_main_load),
    .i_D     (w_main_d),
    .o_Q     (w_main_q)
  );

  pipe_slot #(.W(PW)) u_skid_slot (
    .i_Clk   (i_Clk),
    .i_Rst_n (Reset),
    .i_Load  (w_skid_load),
    .i_D     (w_in_pay),
    .o_Q     (w_skid_q)
  );

  // Bubbles must never carry a live RegWrite/MemtoReg or destination downstream.
  assign o_Data     = w_main_q[PW-1 -: NUM_DATA*DATA_W];
  assign o_WriteReg = o_Valid ? w_main_q[CTRL_W +: REG_W] : '0;
  assign o_Ctrl     = o_Valid ? w_main_q[CTRL_W-1:0] : '0;

  always_ff @(posedge i_Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else if (i_CntClr) begin
      r_cnt <= '0;
    end else if (o_Valid && !i_Ready && (r_cnt != '1)) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_StallCnt = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed plus randomized checks of pipe_stage_reg against a queue model
// Instance 1: SKID=1, CNT_W=16. Instance 0: SKID=0, CNT_W=4.
module tb_pipe_stage_reg;
  import mips_pipe_pkg::*;

  localparam int DW = 32;
  localparam int ND = 2;
  localparam int RW = 5;
  localparam int CW = 2;
  localparam int PW = ND*DW + RW + CW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          iv[2];
  logic          ir[2];
  logic          fl[2];
  logic          cl[2];
  logic [PW-1:0] ip[2];

  logic           ov0, ov1, or0, or1;
  logic [ND*DW-1:0] od0, od1;
  logic [RW-1:0]  ow0, ow1;
  logic [CW-1:0]  oc0, oc1;
  logic [3:0]     sc0;
  logic [15:0]    sc1;

  logic [PW-1:0] q0[$];
  logic [PW-1:0] q1[$];
  int mcnt[2];
  int ncmp = 0;
  int nfail = 0;

  pipe_stage_reg #(.DATA_W(DW), .NUM_DATA(ND), .REG_W(RW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut1 (
    .i_Clk(clk), .Reset(rst_n), .i_Valid(iv[1]), .o_Ready(or1),
    .i_Data(ip[1][PW-1 -: ND*DW]), .i_WriteReg(ip[1][CW +: RW]), .i_Ctrl(ip[1][CW-1:0]),
    .i_Flush(fl[1]), .o_Valid(ov1), .i_Ready(ir[1]), .o_Data(od1), .o_WriteReg(ow1),
    .o_Ctrl(oc1), .i_CntClr(cl[1]), .o_StallCnt(sc1)
  );

  pipe_stage_reg #(.DATA_W(DW), .NUM_DATA(ND), .REG_W(RW), .CTRL_W(CW), .SKID(0), .CNT_W(4)) u_dut0 (
    .i_Clk(clk), .Reset(rst_n), .i_Valid(iv[0]), .o_Ready(or0),
    .i_Data(ip[0][PW-1 -: ND*DW]), .i_WriteReg(ip[0][CW +: RW]), .i_Ctrl(ip[0][CW-1:0]),
    .i_Flush(fl[0]), .o_Valid(ov0), .i_Ready(ir[0]), .o_Data(od0), .o_WriteReg(ow0),
    .o_Ctrl(oc0), .i_CntClr(cl[0]), .o_StallCnt(sc0)
  );

  task automatic cmp(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(int d);
    return (d != 0) ? q1.size() : q0.size();
  endfunction

  // Capacity rule: two entries with registered ready, or one entry with pass-through ready.
  function automatic logic mready(int d);
    if (d != 0) return q1.size() < 2;
    return (q0.size() == 0) || ir[0];
  endfunction

  task automatic check(int d);
    logic [PW-1:0] exp_p;
    logic ev;
    ev = qsize(d) != 0;
    exp_p = '0;
    if (ev) exp_p = (d != 0) ? q1[0] : q0[0];
    cmp($sformatf("d%0d valid", d), 64'((d != 0) ? ov1 : ov0), 64'(ev));
    cmp($sformatf("d%0d ready", d), 64'((d != 0) ? or1 : or0), 64'(mready(d)));
    cmp($sformatf("d%0d writereg", d), 64'((d != 0) ? ow1 : ow0), 64'(exp_p[CW +: RW]));
    cmp($sformatf("d%0d ctrl", d), 64'((d != 0) ? oc1 : oc0), 64'(exp_p[CW-1:0]));
    if (ev) cmp($sformatf("d%0d data", d), 64'((d != 0) ? od1 : od0), 64'(exp_p[PW-1 -: ND*DW]));
    cmp($sformatf("d%0d stallcnt", d), (d != 0) ? 64'(sc1) : 64'(sc0), 64'(mcnt[d]));
  endtask

  task automatic model(int d);
    logic pop, push;
    int mx;
    pop  = (qsize(d) != 0) && ir[d];
    push = iv[d] && mready(d);
    mx   = (d != 0) ? 65535 : 15;
    if (cl[d]) mcnt[d] = 0;
    else if ((qsize(d) != 0) && !ir[d] && (mcnt[d] < mx)) mcnt[d] = mcnt[d] + 1;
    if (fl[d]) begin
      if (d != 0) q1.delete(); else q0.delete();
    end else begin
      if (pop) begin
        if (d != 0) void'(q1.pop_front()); else void'(q0.pop_front());
      end
      if (push) begin
        if (d != 0) q1.push_back(ip[d]); else q0.push_back(ip[d]);
      end
    end
  endtask

  task automatic cycle();
    #1;
    for (int d = 0; d < 2; d++) begin
      check(d);
      model(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(logic v, logic r, logic f, logic c);
    for (int d = 0; d < 2; d++) begin
      iv[d] = v;
      ir[d] = r;
      fl[d] = f;
      cl[d] = c;
      ip[d] = {$urandom, $urandom, 7'($urandom)};
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    cmp("rst d1 valid", 64'(ov1), 64'(0));
    cmp("rst d1 ready", 64'(or1), 64'(1));
    cmp("rst d1 data", 64'(od1), 64'(0));
    cmp("rst d1 writereg", 64'(ow1), 64'(0));
    cmp("rst d1 ctrl", 64'(oc1), 64'(0));
    cmp("rst d1 stallcnt", 64'(sc1), 64'(0));
    cmp("rst d0 valid", 64'(ov0), 64'(0));
    cmp("rst d0 ready", 64'(or0), 64'(1));
    cmp("rst d0 data", 64'(od0), 64'(0));
    cmp("rst d0 writereg", 64'(ow0), 64'(0));
    cmp("rst d0 ctrl", 64'(oc0), 64'(0));
    cmp("rst d0 stallcnt", 64'(sc0), 64'(0));
    q0.delete();
    q1.delete();
    mcnt[0] = 0;
    mcnt[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();

    // Back-to-back streaming with downstream always ready.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle();

    // Backpressure: A then B while stalled, then release.
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    cmp("bp d1 ready low", 64'(or1), 64'(0));
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    cmp("bp d1 stall exact", 64'(sc1), 64'(3));
    cmp("bp d0 stall exact", 64'(sc0), 64'(3));

    // Flush while in the skid state with a simultaneous write-enabled input.
    set_in(1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    ip[0][CW-1:0] = 2'b11;
    ip[1][CW-1:0] = 2'b11;
    cycle();
    cmp("flush d1 valid", 64'(ov1), 64'(0));
    cmp("flush d1 regwrite", 64'(oc1[CTRL_REGWRITE]), 64'(0));
    cmp("flush d1 memtoreg", 64'(oc1[CTRL_MEMTOREG]), 64'(0));
    cmp("flush d1 ready", 64'(or1), 64'(1));
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();

    // Downstream ready toggling 1,0,1 with a continuous stream.
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 1'((i % 3) != 1), 1'b0, 1'b0);
      cycle();
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();

    // Saturation of the 4-bit counter, then clear during an active stall.
    set_in(1'b0, 1'b1, 1'b0, 1'b1);
    cycle();
    for (int i = 0; i < 21; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    cmp("sat d0 stallcnt", 64'(sc0), 64'(15));
    cmp("sat d1 stallcnt", 64'(sc1), 64'(20));
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    cmp("clr d0 stallcnt", 64'(sc0), 64'(0));
    cmp("clr d1 stallcnt", 64'(sc1), 64'(0));
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      set_in(1'(($urandom % 4) != 0), 1'(($urandom % 3) != 0),
             1'(($urandom % 29) == 0), 1'(($urandom % 37) == 0));
      cycle();
    end

    // Reset mid-stream with entries held.
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
